// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Contents: controller state encoding, register-address width and an
// address compare helper in which register 0 never matches.
package pipe_ctrl_pkg;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN     = 2'b00,
    ST_BRSTALL = 2'b01,
    ST_MDWAIT  = 2'b10
  } state_e;

  // Register 0 is hard-wired zero, so a dependency on it is never real.
  function automatic logic addr_match(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
    return (a != ADDR_W'(0)) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational register-dependency detection between Decode and Execute.
// Inputs : Decode source addresses (rs/rt), Execute destination/load target,
//          Execute regwrite/memread controls, Decode branch flag.
// Outputs: o_loaduse - Decode reads the register an Execute load writes
//          o_bralu   - Decode branch reads an Execute ALU result
//          o_brload  - Decode branch reads an Execute load result
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr_rsD,
  input  logic [ADDR_W-1:0] i_addr_rtD,
  input  logic [ADDR_W-1:0] i_addr_rdE,
  input  logic [ADDR_W-1:0] i_addr_rtE,
  input  logic              i_con_regwriteE,
  input  logic              i_con_memreadE,
  input  logic              i_con_branchD,
  output logic              o_loaduse,
  output logic              o_bralu,
  output logic              o_brload
);

  logic load_match;
  logic alu_match;

  assign load_match = addr_match(i_addr_rtE, i_addr_rsD) ||
                      addr_match(i_addr_rtE, i_addr_rtD);
  assign alu_match  = addr_match(i_addr_rdE, i_addr_rsD) ||
                      addr_match(i_addr_rdE, i_addr_rtD);

  assign o_loaduse = i_con_memreadE && load_match;
  // Load results are covered by the load paths; only pure ALU writers here.
  assign o_bralu   = i_con_branchD && i_con_regwriteE && !i_con_memreadE && alu_match;
  assign o_brload  = i_con_branchD && o_loaduse;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use and branch-compare hazards,
// taken-branch flush, multi-cycle mul/div wait, and memory-wait freeze.
// Ports: i_clk/i_rst_n (sync, active-low); Decode/Execute addresses and
// controls; i_md_done, i_mem_ready; stall/flush/freeze controls, o_md_start
// and o_state (debug). Outputs are combinational so stalls act same-cycle.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_addr_rsD,
  input  logic [ADDR_W-1:0] i_addr_rtD,
  input  logic [ADDR_W-1:0] i_addr_rdE,
  input  logic [ADDR_W-1:0] i_addr_rtE,
  input  logic              i_con_regwriteE,
  input  logic              i_con_memreadE,
  input  logic              i_con_branchD,
  input  logic              i_con_takenD,
  input  logic              i_con_mdD,
  input  logic              i_md_done,
  input  logic              i_mem_ready,
  output logic              o_con_stallF,
  output logic              o_con_stallD,
  output logic              o_con_flushD,
  output logic              o_con_flushE,
  output logic              o_con_freeze,
  output logic              o_md_start,
  output logic [1:0]        o_state
);

  state_e state;
  state_e state_nxt;
  logic   loaduse;
  logic   bralu;
  logic   brload;

  hazard_detect u_hazard_detect (
    .i_addr_rsD      (i_addr_rsD),
    .i_addr_rtD      (i_addr_rtD),
    .i_addr_rdE      (i_addr_rdE),
    .i_addr_rtE      (i_addr_rtE),
    .i_con_regwriteE (i_con_regwriteE),
    .i_con_memreadE  (i_con_memreadE),
    .i_con_branchD   (i_con_branchD),
    .o_loaduse       (loaduse),
    .o_bralu         (bralu),
    .o_brload        (brload)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // Next-state and control outputs
  always_comb begin
    state_nxt    = state;
    o_con_stallF = 1'b0;
    o_con_stallD = 1'b0;
    o_con_flushD = 1'b0;
    o_con_flushE = 1'b0;
    o_con_freeze = 1'b0;
    o_md_start   = 1'b0;

    if (!i_rst_n) begin
      state_nxt = ST_RUN;
    end else if (!i_mem_ready) begin
      // Memory wait freezes everything, including a pending mul/div done.
      o_con_freeze = 1'b1;
      o_con_stallF = 1'b1;
      o_con_stallD = 1'b1;
      if (state != ST_RUN && state != ST_BRSTALL && state != ST_MDWAIT)
        state_nxt = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (loaduse || bralu) begin
            o_con_stallF = 1'b1;
            o_con_stallD = 1'b1;
            o_con_flushE = 1'b1;
            if (brload) state_nxt = ST_BRSTALL;
          end else if (i_con_mdD) begin
            o_md_start = 1'b1;
            state_nxt  = ST_MDWAIT;
          end else if (i_con_takenD) begin
            o_con_flushD = 1'b1;
          end
        end
        ST_BRSTALL: begin
          // Second stall cycle so the load result reaches the branch compare.
          o_con_stallF = 1'b1;
          o_con_stallD = 1'b1;
          o_con_flushE = 1'b1;
          state_nxt    = ST_RUN;
        end
        ST_MDWAIT: begin
          if (i_md_done) begin
            state_nxt = ST_RUN;
          end else begin
            o_con_stallF = 1'b1;
            o_con_stallD = 1'b1;
            o_con_flushE = 1'b1;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign o_state = i_rst_n ? STATE_W'(state) : STATE_W'(0);

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have the following ports, one clock domain, clock and reset first:
- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_addr_rsD  in  5  rs of instruction in Decode
- i_addr_rtD  in  5  rt of instruction in Decode
- i_addr_rdE  in  5  destination of instruction in Execute
- i_addr_rtE  in  5  rt (load target) of instruction in Execute
- i_con_regwriteE  in  1  Execute instruction writes register
- i_con_memreadE  in  1  Execute instruction is a load
- i_con_branchD  in  1  Decode instruction is a branch (compare in Decode)
- i_con_takenD  in  1  Decode branch resolved taken
- i_con_mdD  in  1  Decode instruction is multiply/divide
- i_md_done  in  1  multi-cycle mul/div unit finished (one-cycle pulse)
- i_mem_ready  in  1  data memory ready; 0 = wait
- o_con_stallF  out  1  hold PC
- o_con_stallD  out  1  hold IF/ID register
- o_con_flushD  out  1  clear IF/ID register
- o_con_flushE  out  1  insert bubble into ID/EX
- o_con_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- o_md_start  out  1  start pulse to mul/div unit
- o_state  out  2  current state, debug

Function
REQ-002 States SHALL be RUN=2'b00, BRSTALL=2'b01, MDWAIT=2'b10; 2'b11 SHALL be treated as RUN next cycle.
REQ-003 Outputs SHALL be combinational from state and inputs (same-cycle stall); state SHALL update on the rising edge of i_clk.
REQ-004 Register address 0 SHALL never match in any comparison.
REQ-005 Freeze: i_mem_ready=0 SHALL force o_con_freeze=1, o_con_stallF=1, o_con_stallD=1, all flush/start outputs 0, and hold state; this rule SHALL take priority over all others.
REQ-006 Load-use (RUN): i_con_memreadE=1 and i_addr_rtE matches i_addr_rsD or i_addr_rtD SHALL give stallF=stallD=flushE=1 for that cycle, with state staying RUN.
REQ-007 Branch ALU dependency (RUN): i_con_branchD=1, i_con_regwriteE=1, i_con_memreadE=0, and i_addr_rdE matches rsD or rtD SHALL give a one-cycle stallF=stallD=flushE=1.
REQ-008 Branch load dependency (RUN): i_con_branchD=1 with the REQ-006 match SHALL stall this cycle and go to BRSTALL.
REQ-009 BRSTALL SHALL assert stallF=stallD=flushE=1 unconditionally for exactly one cycle, then return to RUN (total two stall cycles).
REQ-010 Taken branch: in RUN with no stall condition, i_con_takenD=1 SHALL assert o_con_flushD=1 for that cycle only.
REQ-011 Mul/div: in RUN with no stall condition, i_con_mdD=1 SHALL assert o_md_start=1 for exactly that cycle and go to MDWAIT.
REQ-012 MDWAIT SHALL assert stallF=stallD=flushE=1 until the cycle i_md_done=1; in that cycle stalls SHALL deassert and the next state SHALL be RUN.
REQ-013 i_md_done outside MDWAIT SHALL be ignored; o_md_start SHALL never be asserted twice without an intervening done.
REQ-014 Priority within RUN SHALL be: load-use/branch stall > mul/div start > taken flush.

Reset
REQ-015 While i_rst_n=0 at a rising edge, the state SHALL become RUN.
REQ-016 While i_rst_n=0, all outputs SHALL be 0 and o_state=2'b00, regardless of other inputs.
REQ-017 Reset asserted mid-MDWAIT or mid-BRSTALL SHALL abandon the operation, with no start re-issued.

Structure
REQ-018 The state enum and encodings SHALL live in shared package pipe_ctrl_pkg.
REQ-019 Address comparison logic SHALL be one combinational sub-module, hazard_detect, producing loaduse, bralu and brload flags.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Load-use: memreadE=1, rtE=5, rsD=5 -> stallF/stallD/flushE=1 for one cycle; rtE=0, rsD=0 -> no stall.
- Branch on load: branchD=1, memreadE=1, rtE=7, rtD=7 -> two consecutive stall cycles, o_state 00->01->00.
- Branch on ALU result: branchD=1, regwriteE=1, rdE=3, rsD=3 -> exactly one stall cycle; takenD=1 afterwards -> flushD=1 for one cycle.
- Mul/div: mdD=1 -> o_md_start pulse, then stall for 10 cycles, then done -> stalls drop in the same cycle.
- Freeze: i_mem_ready=0 for 3 cycles during MDWAIT -> freeze=1, state held at 10, done during freeze ignored until ready.
- Reset mid-MDWAIT -> all outputs 0 next cycle, state RUN, no second start.
